// File: rtl/mul_datapath.sv
// Shift-and-add multiplier datapath that executes micro-op strobes t1..t9 from its controller; there is no backpressure.
// Every micro-op takes effect on the next rising edge; x/y are combinational from state, and done follows t8 by one cycle.
module mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic               t1,
  input  logic               t2,
  input  logic               t3,
  input  logic               t4,
  input  logic               t5,
  input  logic               t6,
  input  logic               t7,
  input  logic               t8,
  input  logic               t9,
  input  logic [WIDTH-1:0]   din_a,
  input  logic [WIDTH-1:0]   din_b,
  output logic               x,
  output logic               y,
  output logic [2*WIDTH-1:0] prod,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_md;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_done;
  logic               r_err;

  logic [WIDTH:0]     w_base;
  logic [WIDTH:0]     w_md_ext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mq_src;
  logic [WIDTH:0]     w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cnt_zero;
  logic               w_err_set;

  assign w_base     = t5 ? '0 : r_acc;
  assign w_md_ext   = {1'b0, r_md};
  assign w_mq_src   = t4 ? din_b : r_mq;
  assign w_cnt_zero = (r_cnt == '0);

  // Add and subtract requested together cancel out; the conflict is flagged below.
  always_comb begin
    w_sum = w_base;
    if (t1 && !t9) begin
      w_sum = w_base + w_md_ext;
    end else if (t9 && !t1) begin
      w_sum = w_base - w_md_ext;
    end
  end

  always_comb begin
    w_acc_nxt = w_sum;
    w_mq_nxt  = w_mq_src;
    if (t2) begin
      w_acc_nxt = {1'b0, w_sum[WIDTH:1]};
      w_mq_nxt  = {w_sum[0], w_mq_src[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (t6) begin
      w_cnt_nxt = CNT_W'(WIDTH);
    end else if (t7) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  assign w_err_set = (t1 && t9) || (t6 && t7) || (!t6 && t7 && w_cnt_zero);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_md   <= '0;
      r_mq   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_mq   <= w_mq_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= t8;
      if (t3) begin
        r_md <= din_a;
      end
      if (t8) begin
        r_prod <= {r_acc[WIDTH-1:0], r_mq};
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign x    = r_mq[0];
  assign y    = w_cnt_zero;
  assign prod = r_prod;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: directed products and micro-op corners plus random strobes,
// all against an integer-arithmetic model of the register file.
module tb_mul_datapath;

  localparam int W = 8;
  localparam logic [9:1] T1 = 9'b000000001;
  localparam logic [9:1] T2 = 9'b000000010;
  localparam logic [9:1] T3 = 9'b000000100;
  localparam logic [9:1] T4 = 9'b000001000;
  localparam logic [9:1] T5 = 9'b000010000;
  localparam logic [9:1] T6 = 9'b000100000;
  localparam logic [9:1] T7 = 9'b001000000;
  localparam logic [9:1] T8 = 9'b010000000;
  localparam logic [9:1] T9 = 9'b100000000;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0, t5 = 1'b0;
  logic t6 = 1'b0, t7 = 1'b0, t8 = 1'b0, t9 = 1'b0;
  logic [W-1:0] din_a = '0;
  logic [W-1:0] din_b = '0;
  logic x, y, done, err;
  logic [2*W-1:0] prod;

  int checks = 0;
  int errors = 0;

  int m_md, m_mq, m_acc, m_cnt, m_prod;
  bit m_done, m_err;

  always #5 clk = ~clk;

  mul_datapath #(.WIDTH(W)) dut (
    .clk(clk), .res(res),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7), .t8(t8), .t9(t9),
    .din_a(din_a), .din_b(din_b),
    .x(x), .y(y), .prod(prod), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_md = 0; m_mq = 0; m_acc = 0; m_cnt = 0; m_prod = 0; m_done = 0; m_err = 0;
  endtask

  // Register-file semantics written as whole-number arithmetic: ACC is kept modulo 512,
  // and the {ACC,MQ} shift is a divide by two of ACC*256+MQ.
  task automatic model_update(input logic [9:1] s, input int a, input int b);
    int base, sum, mqs, comb;
    if (!res) return;
    base = s[5] ? 0 : m_acc;
    if (s[1] && s[9]) begin
      sum = base; m_err = 1;
    end else if (s[1]) sum = (base + m_md) % 512;
    else if (s[9]) sum = (base - m_md + 512) % 512;
    else sum = base;
    mqs = s[4] ? b : m_mq;
    if (s[8]) m_prod = (m_acc % 256) * 256 + m_mq;
    m_done = s[8];
    if (s[2]) begin
      comb = (sum * 256 + mqs) / 2;
      m_acc = comb / 256;
      m_mq = comb % 256;
    end else begin
      m_acc = sum;
      m_mq = mqs;
    end
    if (s[6]) begin
      if (s[7]) m_err = 1;
      m_cnt = W;
    end else if (s[7]) begin
      if (m_cnt == 0) begin
        m_cnt = 15; m_err = 1;
      end else m_cnt = m_cnt - 1;
    end
    if (s[3]) m_md = a;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_x"}, 32'(x), 32'(m_mq % 2));
    chk({tag, "_y"}, 32'(y), 32'(m_cnt == 0));
    chk({tag, "_prod"}, 32'(prod), 32'(m_prod));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic set_strobes(input logic [9:1] s);
    {t9, t8, t7, t6, t5, t4, t3, t2, t1} = s;
  endtask

  task automatic step(input logic [9:1] s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string tag);
    set_strobes(s);
    din_a = a;
    din_b = b;
    model_update(s, int'(a), int'(b));
    @(posedge clk);
    #1;
    set_strobes('0);
    check_all(tag);
  endtask

  task automatic do_reset();
    res = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  // Drives the nominal controller sequence, taking x/y from the DUT the way the controller would.
  task automatic multiply(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                          input bit expect_no_err);
    int iters = 0;
    step(T3 | T4, a, b, tag);
    step(T5 | T6, '0, '0, tag);
    while (y !== 1'b1 && iters < 20) begin
      step(x ? (T1 | T2 | T7) : (T2 | T7), '0, '0, tag);
      iters++;
    end
    chk({tag, "_iters"}, 32'(iters), 32'(W));
    step(T8, '0, '0, tag);
    chk({tag, "_product"}, 32'(prod), 32'(int'(a) * int'(b)));
    chk({tag, "_done_hi"}, 32'(done), 32'd1);
    chk({tag, "_y_end"}, 32'(y), 32'd1);
    if (expect_no_err) chk({tag, "_noerr"}, 32'(err), 32'd0);
    step('0, '0, '0, tag);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    model_reset();
    #1;
    check_all("por");
    chk("por_y_one", 32'(y), 32'd1);
    @(posedge clk);
    #1;
    res = 1'b1;

    // Asynchronous reset in the middle of a multiply.
    step(T3 | T4, 8'd200, 8'd150, "pre");
    step(T5 | T6, '0, '0, "pre");
    step(T1 | T2 | T7, '0, '0, "pre");
    res = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_prod", 32'(prod), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(9'($urandom), 8'($urandom), 8'($urandom), "rst_hold");
      chk("rst_hold_y", 32'(y), 32'd1);
    end
    res = 1'b1;
    step('0, '0, '0, "rst_release");
    step('0, '0, '0, "rst_release");

    multiply(8'd13, 8'd11, "m13x11", 1'b1);
    chk("m13x11_const", 32'(prod), 32'h008F);
    multiply(8'd255, 8'd255, "m255x255", 1'b1);
    chk("m255x255_const", 32'(prod), 32'hFE01);
    multiply(8'd0, 8'd200, "m0x200", 1'b1);
    chk("m0x200_const", 32'(prod), 32'h0000);
    multiply(8'd1, 8'd1, "m1x1", 1'b1);
    chk("m1x1_const", 32'(prod), 32'h0001);
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      multiply(ra, rb, "mrand", 1'b1);
    end

    // Add and shift in one cycle: {0FF,01} >> 1 = {07F,80}.
    step(T3 | T4 | T5, 8'hFF, 8'h01, "addsh");
    step(T1 | T2, '0, '0, "addsh");
    chk("addsh_x", 32'(x), 32'd0);
    step(T8, '0, '0, "addsh");
    chk("addsh_prod", 32'(prod), 32'h7F80);

    // Subtract underflow, then add/sub conflict; the shift exposes ACC's carry bit.
    step(T3 | T4 | T5, 8'h01, 8'h00, "sub");
    step(T9, '0, '0, "sub");
    step(T8, '0, '0, "sub");
    chk("sub_prod", 32'(prod), 32'hFF00);
    step(T1 | T9, '0, '0, "conf");
    chk("conf_err", 32'(err), 32'd1);
    step(T8, '0, '0, "conf");
    chk("conf_acc_hold", 32'(prod), 32'hFF00);
    step(T2, '0, '0, "conf");
    step(T8, '0, '0, "conf");
    chk("conf_carry", 32'(prod), 32'hFF80);
    multiply(8'd3, 8'd5, "sticky", 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);

    // Counter boundary.
    step(T6, '0, '0, "cnt");
    chk("cnt_load_y", 32'(y), 32'd0);
    for (int i = 1; i <= W; i++) begin
      step(T7, '0, '0, "cnt");
      chk("cnt_dec_y", 32'(y), 32'(i == W));
    end
    step(T7, '0, '0, "cnt");
    chk("cnt_wrap_y", 32'(y), 32'd0);
    chk("cnt_wrap_err", 32'(err), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step(T7, '0, '0, "cnt15");
      chk("cnt15_y", 32'(y), 32'(i == 15));
    end
    do_reset();
    step(T6 | T7, '0, '0, "cnt67");
    chk("cnt67_err", 32'(err), 32'd1);
    for (int i = 1; i <= W; i++) begin
      step(T7, '0, '0, "cnt67");
      chk("cnt67_y", 32'(y), 32'(i == W));
    end
    do_reset();

    // Random strobe mixes, with an occasional reset to clear the sticky flag.
    for (int i = 0; i < 300; i++) begin
      if (i % 75 == 74) do_reset();
      step(9'($urandom & $urandom), 8'($urandom), 8'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
- Operational unit (datapath) driven by a micro-program controller. The controller issues one-cycle micro-operation strobes t1..t9; this block executes them and returns the condition flags x and y.
- Together they form a shift-and-add unsigned multiplier. This block is the responder end of the controller's t/x/y interface.
- It holds the register file MD, MQ, ACC and CNT, plus a product output register and status flags.

Parameters:
- WIDTH, 8, operand width in bits. Must be at least 2.
- CNT_W, $clog2(WIDTH+1), counter width. Derived; do not override.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- res  in  1  reset. Asynchronous, active-low. Clears all state.
- t1  in  1  micro-op: ACC <= ACC + MD.
- t2  in  1  micro-op: shift {ACC,MQ} right by 1.
- t3  in  1  micro-op: MD <= din_a.
- t4  in  1  micro-op: MQ <= din_b.
- t5  in  1  micro-op: ACC <= 0.
- t6  in  1  micro-op: CNT <= WIDTH.
- t7  in  1  micro-op: CNT <= CNT - 1.
- t8  in  1  micro-op: latch the product, pulse done.
- t9  in  1  micro-op: ACC <= ACC - MD.
- din_a  in  WIDTH  multiplicand.
- din_b  in  WIDTH  multiplier.
- x  out  1  condition flag, equal to MQ[0].
- y  out  1  condition flag, equal to (CNT == 0).
- prod  out  2*WIDTH  product register.
- done  out  1  one-cycle pulse, asserted the cycle after t8.
- err  out  1  sticky strobe-conflict flag.

Behaviour:
- Registers and widths:
  - MD: WIDTH bits.
  - MQ: WIDTH bits.
  - ACC: WIDTH+1 bits; the extra MSB holds the carry.
  - CNT: CNT_W bits.
  - prod: 2*WIDTH bits.
- Reset (res low, asynchronous): MD, MQ, ACC, CNT, prod, done and err all go to 0. Consequently x=0 and y=1 during and after reset.
- A reset asserted mid-operation aborts the operation immediately. No done is produced.
- x and y are combinational from registered state. The controller samples them on the same edge that applies its next strobes, so there is zero added latency.
- All strobes may be asserted in the same cycle. Every unasserted group holds its value.
- ACC/MQ next-state is computed in this order within one cycle:
  - base = t5 ? 0 : ACC.
  - sum = t1 ? base + MD : (t9 ? base - MD : base). Arithmetic is modulo 2^(WIDTH+1); MD is zero-extended.
  - If t1 and t9 are both high: sum = base, and err is set.
  - mq_src = t4 ? din_b : MQ.
  - If t2 is high: {ACC,MQ} <= {1'b0, sum, mq_src} >> 1, a logical shift with 0 into the MSB.
  - If t2 is low: ACC <= sum and MQ <= mq_src.
- MD: t3 loads din_a. It is used by t1/t9 only from the next cycle onward; t1 with t3 in the same cycle uses the old MD.
- CNT:
  - t6 loads WIDTH.
  - Otherwise t7 decrements. Decrementing from 0 wraps to 2^CNT_W - 1 and sets err.
  - If t6 and t7 are both high, t6 wins and err is set.
- t8: prod <= {ACC[WIDTH-1:0], MQ}, using pre-edge register values. done is high in the following cycle only, then low again unless t8 repeats.
- err: once set, stays set until reset.
- Nominal controller sequence:
  1. t3+t4.
  2. t5+t6.
  3. Repeat until y is sampled high: (x ? t1+t2+t7 : t2+t7).
  4. t8.
- Latency: WIDTH+3 strobe cycles from load to the t8 edge; done follows one cycle later.

Test Plan:
- Reset: hold res low mid-run with random strobes -> all outputs 0 and y=1. Release res with strobes low -> state holds.
- Multiply, WIDTH=8: din_a=13, din_b=11, nominal sequence -> prod=16'h008F, done pulses exactly 1 cycle, err=0, y=1 at the end.
- Corner multiply: 255×255 -> prod=16'hFE01. 0×200 -> prod=0. 1×1 -> prod=1. err=0 for all three.
- Combined add+shift: ACC=0, MD=8'hFF, MQ=8'h01; t1+t2 -> ACC=9'h07F and MQ=8'h80, i.e. {0FF,01} shifted right by 1 gives {07F,80}.
- Subtract and conflict:
  - ACC=0, MD=1, t9 -> ACC=9'h1FF.
  - Then t1+t9 together -> ACC unchanged, err=1, and err stays set until reset.
- Counter boundary:
  - t6 -> y=0.
  - 8× t7 -> y=1 after the 8th edge.
  - A 9th t7 -> CNT=15, y=0, err=1.
  - t6+t7 together -> CNT=8.
